// File: rtl/lvds_tx.sv
`default_nettype none
// ============================================================================
//  Module   : lvds_tx
//  Purpose  : Transmit-side framer for the modem LVDS link. Pops 32-bit I/Q
//             sample words from the TX FIFO and serializes each one as sixteen
//             2-bit symbols, MSB first, one symbol per i_ddr_clk cycle. The
//             I sync (2'b10) and Q sync (2'b01) symbols are inserted by this
//             block; IDLE_SYMBOL is driven whenever no word is in flight.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IDLE_SYMBOL    symbol driven between words; must never be 2'b10, or the
//                   receiver could mistake idle for an I sync symbol.
//  Ports
//    i_ddr_clk      in   1  only clock, all state rises on its posedge
//    i_rst_b        in   1  asynchronous active-low reset
//    i_tx_enable    in   1  allows new words to be fetched (never truncates)
//    i_fifo_empty   in   1  TX FIFO empty flag
//    o_fifo_pull    out  1  FIFO read strobe (combinational); data follows
//                           on i_fifo_data one cycle later
//    i_fifo_data    in  32  FIFO read data, I = [29:16], Q = [13:0]
//    o_ddr_data     out  2  registered symbol to the DDR output primitive
//    o_underrun     out  1  one-cycle pulse when streaming breaks on empty
//    o_debug_state  out  2  current FSM state
// ============================================================================
module lvds_tx #(
  parameter logic [1:0] IDLE_SYMBOL = 2'b00
) (
  input  logic        i_ddr_clk,
  input  logic        i_rst_b,
  input  logic        i_tx_enable,
  input  logic        i_fifo_empty,
  output logic        o_fifo_pull,
  input  logic [31:0] i_fifo_data,
  output logic [1:0]  o_ddr_data,
  output logic        o_underrun,
  output logic [1:0]  o_debug_state
);

  // State encodings are visible on o_debug_state, so they are fixed values.
  typedef enum logic [1:0] {
    st_idle  = 2'b00,
    st_fetch = 2'b01,
    st_tx    = 2'b11
  } state_t;

  localparam logic [1:0] c_sync_i    = 2'b10;
  localparam logic [1:0] c_sync_q    = 2'b01;
  localparam logic [3:0] c_first_sym = 4'd15;
  localparam logic [3:0] c_pull_sym  = 4'd1;
  localparam logic [3:0] c_last_sym  = 4'd0;

  state_t      r_state;
  logic [3:0]  r_sym_count;   // index of the symbol now on o_ddr_data
  logic        r_pulled;      // next word already requested at count 1
  logic [31:0] r_shift;       // remaining symbols, next one in [31:30]
  logic [1:0]  r_ddr_data;
  logic        r_underrun;

  logic [31:0] w_frame;
  logic        w_can_pull;
  logic        w_decision;
  logic        w_pull;
  logic        w_unused_fifo_bits;

  // Sync fields always come from here; FIFO bits [31:30] and [15:14] are
  // deliberately dropped.
  assign w_frame = {c_sync_i, i_fifo_data[29:16], c_sync_q, i_fifo_data[13:0]};
  assign w_unused_fifo_bits = ^{i_fifo_data[31:30], i_fifo_data[15:14]};

  assign w_can_pull = i_tx_enable & ~i_fifo_empty;

  // Count 1 is the only in-word point where the FIFO flags are looked at;
  // pulling here lets the new word land exactly as the last symbol goes out.
  assign w_decision = (r_state == st_tx) && (r_sym_count == c_pull_sym);

  // Gated by reset so no read strobe escapes while the FSM is held.
  assign w_pull = i_rst_b & w_can_pull & ((r_state == st_idle) | w_decision);

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state     <= st_idle;
      r_sym_count <= c_first_sym;
      r_pulled    <= 1'b0;
      r_shift     <= '0;
      r_ddr_data  <= IDLE_SYMBOL;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        st_idle: begin
          r_ddr_data  <= IDLE_SYMBOL;
          r_sym_count <= c_first_sym;
          if (w_can_pull) begin
            r_state <= st_fetch;
          end
        end

        st_fetch: begin
          // FIFO data is valid now, one cycle after the pull.
          r_ddr_data  <= w_frame[31:30];
          r_shift     <= {w_frame[29:0], 2'b00};
          r_sym_count <= c_first_sym;
          r_state     <= st_tx;
        end

        st_tx: begin
          if (r_sym_count == c_last_sym) begin
            if (r_pulled) begin
              // Back-to-back: next word's sync follows with no gap symbol.
              r_ddr_data  <= w_frame[31:30];
              r_shift     <= {w_frame[29:0], 2'b00};
              r_sym_count <= c_first_sym;
              r_pulled    <= 1'b0;
            end else begin
              r_ddr_data  <= IDLE_SYMBOL;
              r_sym_count <= c_first_sym;
              r_state     <= st_idle;
            end
          end else begin
            r_ddr_data  <= r_shift[31:30];
            r_shift     <= {r_shift[29:0], 2'b00};
            r_sym_count <= r_sym_count - 4'd1;
            if (r_sym_count == c_pull_sym) begin
              if (w_can_pull) begin
                r_pulled <= 1'b1;
              end else if (i_tx_enable) begin
                // Only a starved stream counts; a disabled link is not an
                // underrun.
                r_underrun <= 1'b1;
              end
            end
          end
        end

        default: begin
          r_ddr_data  <= IDLE_SYMBOL;
          r_sym_count <= c_first_sym;
          r_pulled    <= 1'b0;
          r_state     <= st_idle;
        end
      endcase
    end
  end

  assign o_fifo_pull   = w_pull;
  assign o_ddr_data    = r_ddr_data;
  assign o_underrun    = r_underrun;
  assign o_debug_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lvds_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lvds_tx
//  Purpose  : Self-checking bench for lvds_tx. Stimulus queues timed
//             expectations; a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lvds_tx;

  localparam int K_DDR   = 0;
  localparam int K_PULL  = 1;
  localparam int K_UR    = 2;
  localparam int K_ST    = 3;
  localparam int K_NPULL = 4;
  localparam int K_NUR   = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_b;
  logic        tx_enable;
  logic        fifo_empty;
  logic        fifo_pull;
  logic [31:0] fifo_rdata;
  logic [1:0]  ddr_data;
  logic        underrun;
  logic [1:0]  debug_state;

  int   cyc;
  int   checks;
  int   errors;
  int   pulls_seen;
  int   ur_seen;
  logic prev_pull;

  exp_t        exp_q[$];
  logic [31:0] mem [0:31];
  int          wr_ptr;
  int          rd_ptr;

  lvds_tx #(.IDLE_SYMBOL(2'b00)) u_dut (
    .i_ddr_clk    (clk),
    .i_rst_b      (rst_b),
    .i_tx_enable  (tx_enable),
    .i_fifo_empty (fifo_empty),
    .o_fifo_pull  (fifo_pull),
    .i_fifo_data  (fifo_rdata),
    .o_ddr_data   (ddr_data),
    .o_underrun   (underrun),
    .o_debug_state(debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc        = 0;
    rd_ptr     = 0;
    fifo_rdata = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: read data appears the cycle after the pull.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_pull && (wr_ptr != rd_ptr)) begin
      fifo_rdata <= mem[rd_ptr % 32];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    checks     = 0;
    errors     = 0;
    pulls_seen = 0;
    ur_seen    = 0;
    prev_pull  = 1'b0;
  end

  always @(negedge clk) begin
    logic [31:0] act;
    string       nm;
    if (fifo_pull) pulls_seen++;
    if (underrun) ur_seen++;
    if (fifo_pull && prev_pull) begin
      errors++;
      $display("FAIL pull_twice cyc %0d: pull high two cycles in a row", cyc);
    end
    prev_pull = fifo_pull;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_expectation cyc %0d kind %0d", exp_q[i].cyc, exp_q[i].kind);
        exp_q.delete(i);
      end else if (exp_q[i].cyc == cyc) begin
        case (exp_q[i].kind)
          K_DDR:   begin act = {30'b0, ddr_data};    nm = "ddr_data";    end
          K_PULL:  begin act = {31'b0, fifo_pull};   nm = "fifo_pull";   end
          K_UR:    begin act = {31'b0, underrun};    nm = "underrun";    end
          K_ST:    begin act = {30'b0, debug_state}; nm = "debug_state"; end
          K_NPULL: begin act = pulls_seen;           nm = "pull_total";  end
          default: begin act = ur_seen;              nm = "underrun_total"; end
        endcase
        checks++;
        if (act !== exp_q[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d actual %0h expected %0h", nm, cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 32] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic exp_add(input int c, input int k, input logic [31:0] v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Expect the first n symbols of a hand-built frame starting at cycle c.
  task automatic exp_frame(input int c, input logic [31:0] f, input int n);
    logic [31:0] fr;
    fr = f;
    for (int i = 0; i < n; i++) begin
      exp_add(c + i, K_DDR, {30'b0, fr[31 - 2*i -: 2]});
    end
  endtask

  int r_c, b_c, c_c, d_c, e_c, f_c, g_c, h_c;

  initial begin
    wr_ptr    = 0;
    rst_b     = 1'b0;
    tx_enable = 1'b1;
    push_word(32'h3FFF_0000);

    // Reset held with FIFO non-empty.
    for (int c = 1; c <= 2; c++) begin
      exp_add(c, K_DDR, 32'd0);
      exp_add(c, K_PULL, 32'd0);
      exp_add(c, K_ST, 32'd0);
    end
    step(3);

    // Single word: I = 3FFF, Q = 0.
    r_c   = cyc;
    rst_b = 1'b1;
    exp_add(r_c, K_PULL, 32'd1);
    exp_add(r_c + 1, K_ST, 32'd1);
    exp_add(r_c + 2, K_ST, 32'd3);
    exp_frame(r_c + 2, 32'hBFFF_4000, 16);
    exp_add(r_c + 16, K_PULL, 32'd0);
    exp_add(r_c + 17, K_UR, 32'd1);
    exp_add(r_c + 18, K_DDR, 32'd0);
    exp_add(r_c + 18, K_ST, 32'd0);
    exp_add(r_c + 18, K_UR, 32'd0);
    exp_add(r_c + 19, K_DDR, 32'd0);
    step(22);

    // Back-to-back, three words.
    b_c = cyc;
    push_word(32'h1234_5678);
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0000);
    exp_add(b_c, K_PULL, 32'd1);
    exp_add(b_c + 16, K_PULL, 32'd1);
    exp_add(b_c + 32, K_PULL, 32'd1);
    exp_frame(b_c + 2, 32'h9234_5678, 16);
    exp_frame(b_c + 18, 32'hBFFF_7FFF, 16);
    exp_frame(b_c + 34, 32'h8000_4000, 16);
    exp_add(b_c + 17, K_UR, 32'd0);
    exp_add(b_c + 33, K_UR, 32'd0);
    step(40);
    tx_enable = 1'b0;
    exp_add(b_c + 48, K_PULL, 32'd0);
    exp_add(b_c + 49, K_UR, 32'd0);
    exp_add(b_c + 50, K_DDR, 32'd0);
    step(15);
    tx_enable = 1'b1;

    // Sync override plus underrun and restart after a break.
    c_c = cyc;
    push_word(32'h4000_8000);
    exp_add(c_c, K_PULL, 32'd1);
    exp_frame(c_c + 2, 32'h8000_4000, 16);
    exp_add(c_c + 16, K_UR, 32'd0);
    exp_add(c_c + 17, K_UR, 32'd1);
    exp_add(c_c + 18, K_UR, 32'd0);
    exp_add(c_c + 18, K_DDR, 32'd0);
    exp_add(c_c + 18, K_ST, 32'd0);
    step(25);
    d_c = cyc;
    push_word(32'hFFFF_FFFF);
    exp_add(d_c, K_PULL, 32'd1);
    exp_add(d_c + 1, K_DDR, 32'd0);
    exp_frame(d_c + 2, 32'hBFFF_7FFF, 16);
    exp_add(d_c + 17, K_UR, 32'd1);
    exp_add(d_c + 18, K_DDR, 32'd0);
    step(22);

    // Enable dropped mid-word: word completes, no further pull.
    e_c = cyc;
    push_word(32'h1234_5678);
    push_word(32'h0000_0000);
    exp_add(e_c, K_PULL, 32'd1);
    exp_frame(e_c + 2, 32'h9234_5678, 16);
    step(7);
    tx_enable = 1'b0;
    exp_add(e_c + 16, K_PULL, 32'd0);
    exp_add(e_c + 17, K_UR, 32'd0);
    exp_add(e_c + 18, K_DDR, 32'd0);
    exp_add(e_c + 19, K_ST, 32'd0);
    step(22);

    // Enable dropped right after the count-1 pull: pulled word still sent.
    f_c = cyc;
    push_word(32'hFFFF_FFFF);
    tx_enable = 1'b1;
    exp_add(f_c, K_PULL, 32'd1);
    exp_frame(f_c + 2, 32'h8000_4000, 16);
    exp_add(f_c + 16, K_PULL, 32'd1);
    step(17);
    tx_enable = 1'b0;
    exp_frame(f_c + 18, 32'hBFFF_7FFF, 16);
    exp_add(f_c + 32, K_PULL, 32'd0);
    exp_add(f_c + 33, K_UR, 32'd0);
    exp_add(f_c + 34, K_DDR, 32'd0);
    step(38);

    // Reset mid-word, then a clean restart.
    tx_enable = 1'b1;
    g_c = cyc;
    push_word(32'h1234_5678);
    exp_add(g_c, K_PULL, 32'd1);
    exp_frame(g_c + 2, 32'h9234_5678, 5);
    step(7);
    rst_b = 1'b0;
    exp_add(g_c + 7, K_DDR, 32'd0);
    exp_add(g_c + 7, K_ST, 32'd0);
    exp_add(g_c + 7, K_PULL, 32'd0);
    step(2);
    rst_b = 1'b1;
    exp_add(g_c + 10, K_DDR, 32'd0);
    exp_add(g_c + 10, K_ST, 32'd0);
    step(3);
    h_c = cyc;
    push_word(32'hFFFF_FFFF);
    exp_add(h_c, K_PULL, 32'd1);
    exp_frame(h_c + 2, 32'hBFFF_7FFF, 16);
    exp_add(h_c + 17, K_UR, 32'd1);
    exp_add(h_c + 18, K_DDR, 32'd0);
    step(22);

    // Totals over the whole run.
    exp_add(cyc + 1, K_NPULL, 32'd11);
    exp_add(cyc + 1, K_NUR, 32'd4);
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
